// File: rtl/register_file_if.sv
// register_file_if
//   Bus bundle for the 32 x 32-bit register file: one write port and two
//   independent combinational read ports.
//   master : decode/writeback side; drives the addresses, write enable and
//            write data, and receives the two read values.
//   slave  : register file side.
`timescale 1ns/1ps

interface register_file_if;
  logic        write_en;
  logic [4:0]  write_reg_addr;
  logic [4:0]  read_reg_a_addr;
  logic [4:0]  read_reg_b_addr;
  logic [31:0] write_reg_data_in;
  logic [31:0] reg_a_data_out;
  logic [31:0] reg_b_data_out;

  modport master (
    output write_en,
    output write_reg_addr,
    output read_reg_a_addr,
    output read_reg_b_addr,
    output write_reg_data_in,
    input  reg_a_data_out,
    input  reg_b_data_out
  );

  modport slave (
    input  write_en,
    input  write_reg_addr,
    input  read_reg_a_addr,
    input  read_reg_b_addr,
    input  write_reg_data_in,
    output reg_a_data_out,
    output reg_b_data_out
  );
endinterface

// File: rtl/register_file.sv
// register_file
//   32-entry x 32-bit general-purpose register file for the MIPS datapath.
//   Register 0 reads as zero and ignores writes.
//   Ports:
//     clock : system clock, rising-edge active
//     reset : asynchronous, active-high; clears every register
//     bus   : register_file_if.slave
//             write_en / write_reg_addr / write_reg_data_in : synchronous write
//             read_reg_a_addr -> reg_a_data_out : combinational read port A
//             read_reg_b_addr -> reg_b_data_out : combinational read port B
//   Reads return the pre-edge contents; there is no write-to-read bypass.
`timescale 1ns/1ps

module register_file (
  input logic             clock,
  input logic             reset,
  register_file_if.slave  bus
);

  logic [31:0] regs [32];

  // Entry 0 is cleared by reset and never written; the read mux also forces
  // address 0 to zero so $zero holds regardless of storage contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.write_en && (bus.write_reg_addr != 5'd0)) begin
      regs[bus.write_reg_addr] <= bus.write_reg_data_in;
    end
  end

  assign bus.reg_a_data_out = (bus.read_reg_a_addr == 5'd0) ? 32'h0000_0000
                                                            : regs[bus.read_reg_a_addr];
  assign bus.reg_b_data_out = (bus.read_reg_b_addr == 5'd0) ? 32'h0000_0000
                                                            : regs[bus.read_reg_b_addr];

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps

module tb_register_file;

  logic clock = 1'b0;
  logic reset = 1'b0;

  register_file_if bus();

  register_file dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference contents: what each register architecturally holds.
  logic [31:0] model [32];

  task automatic clear_model;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic apply(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    bus.write_en          = we;
    bus.write_reg_addr    = wa;
    bus.write_reg_data_in = wd;
    bus.read_reg_a_addr   = ra;
    bus.read_reg_b_addr   = rb;
  endtask

  // Rising edge: architectural update, then move 1 ns past the edge.
  task automatic advance;
    @(posedge clock);
    if (reset) clear_model();
    else if (bus.write_en && bus.write_reg_addr != 5'd0)
      model[bus.write_reg_addr] = bus.write_reg_data_in;
    #1;
  endtask

  task automatic test_reset;
    clear_model();
    apply(1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd31);
    #2 reset = 1'b1;
    #3;
    vectors++;
    if (bus.reg_a_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_during_a: got %h expected %h", bus.reg_a_data_out, 32'h0);
    end
    vectors++;
    if (bus.reg_b_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_during_b: got %h expected %h", bus.reg_b_data_out, 32'h0);
    end
    advance();
    reset = 1'b0;
    apply(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    @(negedge clock);
    vectors++;
    if (bus.reg_a_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_a5: got %h expected %h", bus.reg_a_data_out, 32'h0);
    end
    vectors++;
    if (bus.reg_b_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_b31: got %h expected %h", bus.reg_b_data_out, 32'h0);
    end
    advance();
  endtask

  task automatic test_write_read;
    apply(1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd0);
    @(negedge clock);
    vectors++;
    if (bus.reg_a_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL no_bypass_a3: got %h expected %h", bus.reg_a_data_out, 32'h0);
    end
    advance();
    apply(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    @(negedge clock);
    vectors++;
    if (bus.reg_a_data_out !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_read_a3: got %h expected %h", bus.reg_a_data_out, 32'hDEAD_BEEF);
    end
    vectors++;
    if (bus.reg_b_data_out !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_read_b3: got %h expected %h", bus.reg_b_data_out, 32'hDEAD_BEEF);
    end
    advance();
  endtask

  task automatic test_r0;
    apply(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    advance();
    apply(1'b0, 5'd0, 32'h0, 5'd0, 5'd3);
    @(negedge clock);
    vectors++;
    if (bus.reg_a_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_read_a: got %h expected %h", bus.reg_a_data_out, 32'h0);
    end
    vectors++;
    if (bus.reg_b_data_out !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL r0_neighbour_b3: got %h expected %h", bus.reg_b_data_out, 32'hDEAD_BEEF);
    end
    advance();
  endtask

  task automatic test_we_gating;
    apply(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
    advance();
    apply(1'b0, 5'd7, 32'hAAAA_AAAA, 5'd7, 5'd7);
    advance();
    apply(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    @(negedge clock);
    vectors++;
    if (bus.reg_a_data_out !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL we_gating_a7: got %h expected %h", bus.reg_a_data_out, 32'h1234_5678);
    end
    vectors++;
    if (bus.reg_b_data_out !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL we_gating_b7: got %h expected %h", bus.reg_b_data_out, 32'h1234_5678);
    end
    advance();
  endtask

  task automatic test_dual_ports;
    apply(1'b1, 5'd1, 32'h0000_0001, 5'd0, 5'd0);
    advance();
    apply(1'b1, 5'd31, 32'h8000_0000, 5'd0, 5'd0);
    advance();
    apply(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
    @(negedge clock);
    vectors++;
    if (bus.reg_a_data_out !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL dual_a31: got %h expected %h", bus.reg_a_data_out, 32'h8000_0000);
    end
    vectors++;
    if (bus.reg_b_data_out !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL dual_b1: got %h expected %h", bus.reg_b_data_out, 32'h0000_0001);
    end
    apply(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    vectors++;
    if (bus.reg_a_data_out !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL swap_a1: got %h expected %h", bus.reg_a_data_out, 32'h0000_0001);
    end
    vectors++;
    if (bus.reg_b_data_out !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL swap_b31: got %h expected %h", bus.reg_b_data_out, 32'h8000_0000);
    end
    advance();
  endtask

  task automatic test_async_reset;
    apply(1'b1, 5'd3, 32'hDEAD_BEEF, 5'd0, 5'd0);
    advance();
    apply(1'b1, 5'd4, 32'h5555_5555, 5'd3, 5'd4);
    #4;
    reset = 1'b1;
    clear_model();
    #1;
    vectors++;
    if (bus.reg_a_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL async_clear_a3: got %h expected %h", bus.reg_a_data_out, 32'h0);
    end
    advance();
    reset = 1'b0;
    apply(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    @(negedge clock);
    vectors++;
    if (bus.reg_a_data_out !== model[3]) begin
      miscompares++;
      $display("FAIL after_reset_a3: got %h expected %h", bus.reg_a_data_out, model[3]);
    end
    vectors++;
    if (bus.reg_b_data_out !== model[4]) begin
      miscompares++;
      $display("FAIL write_in_reset_b4: got %h expected %h", bus.reg_b_data_out, model[4]);
    end
    advance();
    apply(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd3);
    advance();
    apply(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    @(negedge clock);
    vectors++;
    if (bus.reg_a_data_out !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL rewrite_a3: got %h expected %h", bus.reg_a_data_out, 32'hCAFE_F00D);
    end
    advance();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 5'd9, $urandom, 5'd9, 5'd9);
      @(negedge clock);
      vectors++;
      if (bus.reg_a_data_out !== model[9]) begin
        miscompares++;
        $display("FAIL b2b_a9 step %0d: got %h expected %h", i, bus.reg_a_data_out, model[9]);
      end
      vectors++;
      if (bus.reg_b_data_out !== model[9]) begin
        miscompares++;
        $display("FAIL b2b_b9 step %0d: got %h expected %h", i, bus.reg_b_data_out, model[9]);
      end
      advance();
    end
  endtask

  task automatic test_random;
    logic [4:0] wa, ra, rb;
    for (int i = 0; i < 300; i++) begin
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      apply(1'($urandom_range(0, 1)), wa, $urandom, ra, rb);
      @(negedge clock);
      vectors++;
      if (bus.reg_a_data_out !== model[ra]) begin
        miscompares++;
        $display("FAIL random_a iter %0d addr %0d: got %h expected %h", i, ra, bus.reg_a_data_out, model[ra]);
      end
      vectors++;
      if (bus.reg_b_data_out !== model[rb]) begin
        miscompares++;
        $display("FAIL random_b iter %0d addr %0d: got %h expected %h", i, rb, bus.reg_b_data_out, model[rb]);
      end
      advance();
    end
  endtask

  initial begin
    apply(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    clear_model();
    test_reset();
    test_write_read();
    test_r0();
    test_we_gating();
    test_dual_ports();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
